// File: rtl/sobel_result_writer.sv
// sobel_result_writer: back end of the edge-detection datapath.
// Takes Sobel magnitude pixels over a valid/ready handshake, thresholds each
// one against the threshold latched at start, writes one edge bit per pixel
// into the result frame RAM, counts edge pixels and pulses done per frame.
// Optional feature macro: SOBEL_BORDER_CLEAR_EN (forces border pixels to 0).
//
// Handshake: a pixel is transferred on a rising clock edge where
// pixel_valid && pixel_ready. pixel_ready comes from the state register only
// and never looks at pixel_valid; the upstream may hold or drop pixel_valid freely.
module sobel_result_writer #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int ADDR_W     = 12,
    parameter int PIX_W      = 11
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [6:0]        thres_switch,
    input  logic              pixel_valid,
    input  logic [PIX_W-1:0]  pixel_data,
    output logic              pixel_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   edge_count,
    output logic [1:0]        state_dbg
);

    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(IMG_WIDTH * IMG_HEIGHT - 1);
`ifdef SOBEL_BORDER_CLEAR_EN
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [6:0]          thres_q, thres_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                wr_data_q, wr_data_d;
    logic [ADDR_W:0]     edge_count_q, edge_count_d;

    logic                beat;
    logic                raw_edge;
    logic                edge_bit;

    // Edge decision for the pixel currently on the bus (top 7 magnitude bits vs threshold).
    always_comb begin
        raw_edge = (pixel_data[PIX_W-1 -: 7] > thres_q);
`ifdef SOBEL_BORDER_CLEAR_EN
        edge_bit = raw_edge && !((col_q == '0) || (col_q == COL_LAST) ||
                                 (row_q == '0) || (row_q == ROW_LAST));
`else
        edge_bit = raw_edge;
`endif
        beat = pixel_valid && (state_q == ST_RUN);
    end

    // Next-state and datapath: one write per beat, last beat of the frame exits RUN.
    always_comb begin
        state_d      = state_q;
        thres_d      = thres_q;
        col_d        = col_q;
        row_d        = row_q;
        idx_d        = idx_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        edge_count_d = edge_count_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_RUN;
                    thres_d      = thres_switch;
                    edge_count_d = '0;
                    col_d        = '0;
                    row_d        = '0;
                    idx_d        = '0;
                end
            end
            ST_RUN: begin
                if (beat) begin
                    wr_en_d      = 1'b1;
                    wr_addr_d    = idx_q;
                    wr_data_d    = edge_bit;
                    edge_count_d = edge_count_q + (ADDR_W+1)'(edge_bit);
                    idx_d        = idx_q + ADDR_W'(1);
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any partial frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            thres_q      <= '0;
            col_q        <= '0;
            row_q        <= '0;
            idx_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 1'b0;
            edge_count_q <= '0;
        end else begin
            state_q      <= state_d;
            thres_q      <= thres_d;
            col_q        <= col_d;
            row_q        <= row_d;
            idx_q        <= idx_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            edge_count_q <= edge_count_d;
        end
    end

    assign pixel_ready = (state_q == ST_RUN);
    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign edge_count  = edge_count_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_sobel_result_writer.sv
// Directed bench for sobel_result_writer on an 8x4 frame.
// A negedge monitor pops the expected-write queue for every wr_en cycle.
module tb_sobel_result_writer;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int AW = 5;
  localparam int PW = 11;
  localparam int QW = AW + 1;

  logic          clock;
  logic          reset_n;
  logic          start;
  logic [6:0]    thres_switch;
  logic          pixel_valid;
  logic [PW-1:0] pixel_data;
  logic          pixel_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          wr_data;
  logic          busy;
  logic          done;
  logic [AW:0]   edge_count;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;
  int exp_idx = 0;
  int exp_cnt = 0;
  logic [QW-1:0] exp_q[$];

  sobel_result_writer #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .ADDR_W    (AW),
    .PIX_W     (PW)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .thres_switch(thres_switch),
    .pixel_valid (pixel_valid),
    .pixel_data  (pixel_data),
    .pixel_ready (pixel_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .edge_count  (edge_count),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_border(input int idx);
`ifdef SOBEL_BORDER_CLEAR_EN
    return ((idx % W) == 0) || ((idx % W) == W - 1) || ((idx / W) == 0) || ((idx / W) == H - 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [6:0] thr);
    start = 1'b1;
    thres_switch = thr;
    tick();
    start = 1'b0;
    exp_idx = 0;
    exp_cnt = 0;
    check("start_busy", busy, 1);
    check("start_ready", pixel_ready, 1);
    check("start_cnt_clr", edge_count, 0);
    check("start_wr_en", wr_en, 0);
  endtask

  // One accepted pixel; raw is the hand-computed threshold outcome.
  task automatic beat(input logic [PW-1:0] data, input bit raw);
    bit b;
    pixel_valid = 1'b1;
    pixel_data = data;
    b = raw && !is_border(exp_idx);
    exp_q.push_back({AW'(exp_idx), b});
    exp_cnt += int'(b);
    exp_idx++;
    tick();
    pixel_valid = 1'b0;
  endtask

  task automatic check_done();
    check("done_pulse", done, 1);
    check("done_wr_en", wr_en, 1);
    check("done_wr_addr", wr_addr, W * H - 1);
    check("done_cnt", edge_count, exp_cnt);
    check("done_busy", busy, 0);
    tick();
    check("after_done", done, 0);
    check("after_busy", busy, 0);
    check("after_ready", pixel_ready, 0);
    check("after_state", state_dbg, 0);
    check("after_cnt_hold", edge_count, exp_cnt);
  endtask

  // scoreboard: every write must match the head of the expected queue
  always @(negedge clock) begin
    if (wr_en) begin
      check("wr_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        logic [QW-1:0] e;
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e[QW-1:1]);
        check("wr_data", wr_data, e[0]);
      end
    end
  end

  initial begin
    reset_n = 1'b1;
    start = 1'b0;
    thres_switch = 7'd0;
    pixel_valid = 1'b0;
    pixel_data = '0;

    // 1: reset, then idle with valid asserted
    #2 reset_n = 1'b0;
    #1;
    check("rst_state", state_dbg, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_cnt", edge_count, 0);
    tick();
    tick();
    reset_n = 1'b1;
    pixel_valid = 1'b1;
    pixel_data = 11'h7FF;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("idle_ready", pixel_ready, 0);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_wr_en", wr_en, 0);
      check("idle_cnt", edge_count, 0);
    end
    pixel_valid = 1'b0;

    // 2: thres=0, all-ones pixels, continuous valid
    do_start(7'd0);
    for (int i = 0; i < W * H; i++) begin
      beat(11'h7FF, 1'b1);
      check("s2_cnt", edge_count, exp_cnt);
      if (i < W * H - 1) check("s2_no_done", done, 0);
    end
`ifdef SOBEL_BORDER_CLEAR_EN
    check("s2_total", exp_cnt, 12);
`else
    check("s2_total", exp_cnt, 32);
`endif
    check_done();

    // 3: thres latched at start; switches changed mid-frame
    do_start(7'd64);
    thres_switch = 7'd0;
    for (int i = 0; i < W * H; i++) begin
      beat((i % 2) ? 11'h420 : 11'h400, (i % 2) == 1);
    end
    check_done();

    // 4: valid bubbles every other cycle, start pulsed mid-frame
    do_start(7'd0);
    for (int i = 0; i < W * H; i++) begin
      beat((i % 3 == 0) ? 11'h7FF : 11'h000, (i % 3) == 0);
      if (i != W * H - 1) begin
        check("s4_wr_beat", wr_en, 1);
        if (i == 10) start = 1'b1;
        tick();
        start = 1'b0;
        check("s4_wr_gap", wr_en, 0);
        check("s4_busy", busy, 1);
      end
    end
    check_done();

    // 5: reset after 10 beats, then a fresh frame from address 0
    do_start(7'd0);
    for (int i = 0; i < 10; i++) begin
      beat(11'h7FF, 1'b1);
    end
    check("s5_last_wr_en", wr_en, 1);
    check("s5_last_addr", wr_addr, 9);
    check("s5_cnt_pre", edge_count, exp_cnt);
    void'(exp_q.pop_back());
    reset_n = 1'b0;
    #1;
    check("s5_rst_wr_en", wr_en, 0);
    check("s5_rst_ready", pixel_ready, 0);
    check("s5_rst_busy", busy, 0);
    check("s5_rst_cnt", edge_count, 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    do_start(7'd50);
    for (int i = 0; i < W * H; i++) begin
      beat(PW'(i * 64), i >= 13);
    end
    check_done();

    // 6: thres=127 is the top of range, nothing exceeds it
    do_start(7'd127);
    for (int i = 0; i < W * H; i++) begin
      beat(11'h7FF, 1'b0);
    end
    check("s6_total", exp_cnt, 0);
    check_done();

    tick();
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sobel_result_writer.md
Name: sobel_result_writer

Overview:
- Back end of the edge-detection datapath. Accepts the Sobel magnitude pixel stream through a valid/ready handshake.
- Thresholds each pixel against the slide-switch threshold and writes one binary edge bit per pixel into the result frame RAM.
- Counts edge pixels per frame for the seven-segment display logic, and signals frame completion to the top-level state machine.

Parameters:
- IMG_WIDTH, 64, pixels per row.
- IMG_HEIGHT, 64, rows per frame.
- ADDR_W, 12, frame RAM address width. Requirement: 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT.
- PIX_W, 11, magnitude pixel width. Requirement: PIX_W >= 7.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to capture one frame.
- thres_switch  in  7  edge threshold, latched at start.
- pixel_valid  in  1  upstream pixel present.
- pixel_data  in  PIX_W  Sobel magnitude.
- pixel_ready  out  1  writer accepts the pixel this cycle.
- wr_en  out  1  frame RAM write strobe.
- wr_addr  out  ADDR_W  frame RAM address.
- wr_data  out  1  edge bit.
- busy  out  1  frame capture in progress.
- done  out  1  one-cycle frame-complete pulse.
- edge_count  out  ADDR_W+1  number of edge pixels in the current or last frame.

Behaviour:
- Reset (reset_n low, takes effect immediately): state=IDLE. All outputs are 0 (pixel_ready, wr_en, wr_addr, wr_data, busy, done, edge_count). Internal thres, col, row and pixel index registers are 0.
- Beat: a pixel is accepted on a rising edge where pixel_valid && pixel_ready.
- pixel_ready = (state==RUN), decoded from the state register only. It never depends on pixel_valid.
- busy = (state==RUN).
- State machine:
  - IDLE: start=1 -> RUN. On that edge, latch thres_switch into thres, clear edge_count, clear col/row/index. pixel_valid is ignored in IDLE.
  - RUN: each beat writes one pixel. The beat with index IMG_WIDTH*IMG_HEIGHT-1 -> DONE. start is ignored in RUN.
  - DONE: done=1 for exactly one cycle, then -> IDLE unconditionally. start is ignored in DONE.
- Edge decision: edge = (pixel_data[PIX_W-1 -: 7] > thres). The comparison is strict unsigned, so thres=127 yields no edges.
- Write latency is one cycle. wr_en, wr_addr and wr_data are registered on the accepting edge, so wr_en is high during the cycle after the beat. wr_en is 0 whenever no beat was accepted on the previous edge.
- wr_addr equals the pixel index: row*IMG_WIDTH+col, running 0..IMG_WIDTH*IMG_HEIGHT-1 with no gaps regardless of pixel_valid bubbles.
- col/row: col wraps IMG_WIDTH-1 -> 0 and increments row. The index never wraps inside a frame, because the last beat exits RUN.
- edge_count increments on the same edge that registers a write with wr_data=1. It never saturates, since its width covers a full frame.
- Final write and done coincide: during the DONE cycle wr_en=1 (last pixel) and edge_count already holds the final value.
- edge_count holds after DONE until the next accepted start.
- Reset mid-frame: wr_en drops asynchronously and the partial frame is abandoned. The next start restarts at address 0.
- Simultaneous reset_n low with start: reset wins.

Optional Feature:
- Macro: SOBEL_BORDER_CLEAR_EN.
- Defined: pixels with col==0, col==IMG_WIDTH-1, row==0 or row==IMG_HEIGHT-1 are written with wr_data=0 regardless of magnitude, and are never counted. Writes, addresses and timing are otherwise unchanged.
- Undefined: border pixels are thresholded like every other pixel.

Test Plan:
All scenarios use IMG_WIDTH=8, IMG_HEIGHT=4, ADDR_W=5, PIX_W=11.
1. Assert reset_n=0, then release without start; drive pixel_valid=1 -> pixel_ready, wr_en, busy, done and edge_count stay 0, and no writes occur.
2. Pulse start with thres_switch=0, then stream 32 beats of 11'h7FF with continuous valid -> 32 writes at wr_addr 0..31, each wr_data=1. done=1 for one cycle, coinciding with the addr-31 write. edge_count=32. Back in IDLE the next cycle.
3. Pulse start with thres_switch=64, then change the switches to 0 mid-frame. Stream alternating 11'h400 (top7=64) and 11'h420 (top7=66) -> wr_data alternates 0,1 and edge_count=16, confirming thres was latched at start.
4. Toggle pixel_valid every other cycle and pulse start again mid-frame -> writes occur only the cycle after accepted beats, addresses stay contiguous 0..31, the restart pulse is ignored, and edge_count is unaffected by the gaps.
5. Drop reset_n after 10 beats -> wr_en and pixel_ready go 0 immediately and edge_count=0. A new start rewrites from wr_addr=0.
6. With SOBEL_BORDER_CLEAR_EN defined, stream all 11'h7FF with thres=0 -> only the 12 interior pixels (cols 1..6, rows 1..2) get wr_data=1. Border addresses (e.g. 0, 7, 8, 31) get wr_data=0. edge_count=12.
